// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI-to-register bridge.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RWAIT = 2'd2,
    RDATA = 2'd3
  } state_e;

  localparam logic [3:0] STATUS_BASE = 4'hA;
  localparam logic [7:0] ERR_BYTE    = 8'hEE;
  localparam int         RW_BIT      = 7;

  typedef struct packed {
    logic timeout;
    logic late;
    logic short_frame;
  } err_flags_t;

  function automatic logic [7:0] status_byte(input err_flags_t f);
    return {STATUS_BASE, 1'b0, f.timeout, f.late, f.short_frame};
  endfunction

endpackage

// File: rtl/spi_reg_bridge.sv
// Two-byte SPI transaction decoder driving a simple register bus:
// command {rw, addr} followed by write data or the read reply.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       done,
  input  logic [7:0] rx_byte,
  output logic [7:0] tx_byte,
  output logic [6:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_we,
  output logic       bus_re,
  input  logic [7:0] bus_rdata,
  input  logic       bus_rvalid
);

  state_e      state_q, state_d, state_mid;
  err_flags_t  flags_q, flags_d;
  logic        in_byte_q, in_byte_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d, tmo_cnt_inc;
  logic [7:0]  tx_byte_q, tx_byte_d;
  logic [6:0]  bus_addr_q, bus_addr_d;
  logic [7:0]  bus_wdata_q, bus_wdata_d;
  logic        bus_we_q, bus_we_d;
  logic        bus_re_q, bus_re_d;

  logic done_v, short_ev, late_ev, tmo_ev, rvalid_acc, cmd_done;

  // A done only counts when it closes a byte that was opened by start.
  assign done_v      = done & in_byte_q;
  assign short_ev    = start & in_byte_q & ~done;
  assign cmd_done    = (state_q == IDLE) & done_v;
  assign tmo_cnt_inc = tmo_cnt_q + 16'd1;
  assign tmo_ev      = (TIMEOUT != 16'd0) && (state_q != IDLE) && !start && !done_v
                       && (tmo_cnt_inc == TIMEOUT);
  assign late_ev     = start & ~short_ev & (state_mid == RWAIT);
  assign rvalid_acc  = (state_q == RWAIT) & bus_rvalid & ~start & ~tmo_ev;

  // NOTE: async reset in the sensitivity list; every flop gets a defined reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A done is applied before a start arriving in the same cycle: state_mid is
  // the state after the done, and the start is then judged against it.
  always_comb begin
    // NOTE: default assignment first so no path leaves a comb variable unassigned (no latch).
    state_mid = state_q;
    if (done_v) begin
      case (state_q)
        IDLE:         state_mid = rx_byte[RW_BIT] ? RWAIT : WDATA;
        WDATA, RDATA: state_mid = IDLE;
        default:      state_mid = state_q;
      endcase
    end
    state_d = state_mid;
    if (short_ev || tmo_ev)       state_d = IDLE;
    else if (late_ev || rvalid_acc) state_d = RDATA;
  end

  always_comb begin
    flags_d = flags_q;
    // Status is latched by the slave on a start seen in IDLE; set events win.
    if (start && state_d == IDLE) flags_d = '0;
    if (short_ev) flags_d.short_frame = 1'b1;
    if (late_ev)  flags_d.late        = 1'b1;
    if (tmo_ev)   flags_d.timeout     = 1'b1;

    in_byte_d = in_byte_q;
    if (done)  in_byte_d = 1'b0;
    if (start) in_byte_d = 1'b1;

    if (state_d == IDLE || start || done_v || TIMEOUT == 16'd0) tmo_cnt_d = 16'd0;
    else                                                        tmo_cnt_d = tmo_cnt_inc;

    bus_addr_d  = cmd_done ? rx_byte[6:0] : bus_addr_q;
    bus_wdata_d = (state_q == WDATA && done_v) ? rx_byte : bus_wdata_q;
    bus_we_d    = (state_q == WDATA) & done_v;
    bus_re_d    = cmd_done & rx_byte[RW_BIT];

    tx_byte_d = tx_byte_q;
    case (state_d)
      IDLE, WDATA: tx_byte_d = status_byte(flags_d);
      RWAIT:       if (state_q != RWAIT) tx_byte_d = ERR_BYTE;
      RDATA: begin
        if (rvalid_acc)   tx_byte_d = bus_rdata;
        else if (late_ev) tx_byte_d = ERR_BYTE;
      end
      default:     tx_byte_d = tx_byte_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q     <= '0;
      in_byte_q   <= 1'b0;
      tmo_cnt_q   <= 16'd0;
      tx_byte_q   <= {STATUS_BASE, 4'h0};
      bus_addr_q  <= 7'd0;
      bus_wdata_q <= 8'd0;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      in_byte_q   <= in_byte_d;
      tmo_cnt_q   <= tmo_cnt_d;
      tx_byte_q   <= tx_byte_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
    end
  end

  assign tx_byte   = tx_byte_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;

endmodule
